// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Decode/issue pipeline register in front of the execute-stage ALU. Each
// RV32I instruction is decoded into the ALU control nibble {esp_fun, funct3},
// the two ALU operands and the memory/writeback side-band. The result is held
// in one valid/ready handshaked register with one cycle of latency.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready = !out_valid | out_ready)
//   in_instr, in_pc   instruction word and its address
//   in_rs1, in_rs2    register-file read values
//   flush             kill the held bundle and any incoming transfer
//   out_valid/ready   downstream handshake
//   out_alu_ctrl      {esp_fun, funct3} for the ALU
//   out_in1, out_in2  ALU operands
//   out_br_target     pc + B-immediate
//   out_link          pc + 4
//   out_store_data    rs2 value for stores
//   out_rd            destination register
//   out_funct3        raw funct3 (load/store width)
//   out_reg_write     writes rd (never for x0)
//   out_mem_read      load
//   out_mem_write     store
//   out_is_branch     conditional branch
//   out_is_jump       JAL/JALR
//   out_illegal       unsupported or malformed encoding
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_ctrl,
  output logic [31:0] out_in1,
  output logic [31:0] out_in2,
  output logic [31:0] out_br_target,
  output logic [31:0] out_link,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_funct3,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_is_branch,
  output logic        out_is_jump,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] br_target;
    logic [31:0] link;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  bundle_t dec;
  bundle_t held;
  logic    legal;
  logic    rw_raw;
  logic    mr_raw;
  logic    mw_raw;
  logic    br_raw;
  logic    jmp_raw;
  logic    is_shift;
  logic    load;

  // Combinational decode of the incoming instruction. Each opcode sets its
  // operands and raw enables plus a legality flag; the enables are then
  // gated by legality so an illegal instruction never has side effects.
  // Shift-immediates pass only the 5-bit shamt as operand 2 so the funct7
  // bits that select arithmetic shift never leak into the shift amount.
  always_comb begin
    dec            = '0;
    legal          = 1'b0;
    rw_raw         = 1'b0;
    mr_raw         = 1'b0;
    mw_raw         = 1'b0;
    br_raw         = 1'b0;
    jmp_raw        = 1'b0;
    is_shift       = (funct3 == 3'b001) || (funct3 == 3'b101);

    dec.br_target  = in_pc + imm_b;
    dec.link       = in_pc + 32'd4;
    dec.store_data = in_rs2;
    dec.rd         = rd;
    dec.funct3     = funct3;

    case (opcode)
      OPC_OP: begin
        dec.alu_ctrl = {in_instr[30], funct3};
        dec.in1      = in_rs1;
        dec.in2      = in_rs2;
        rw_raw       = 1'b1;
        if (STRICT_DECODE)
          legal = (funct7 == F7_ZERO) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        else
          legal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.alu_ctrl = {(funct3 == 3'b101) ? in_instr[30] : 1'b0, funct3};
        dec.in1      = in_rs1;
        dec.in2      = is_shift ? {27'b0, in_instr[24:20]} : imm_i;
        rw_raw       = 1'b1;
        legal        = !(STRICT_DECODE && is_shift &&
                         !((funct7 == F7_ZERO) || (funct7 == F7_ALT)));
      end
      OPC_LOAD: begin
        dec.in1 = in_rs1;
        dec.in2 = imm_i;
        rw_raw  = 1'b1;
        mr_raw  = 1'b1;
        legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OPC_STORE: begin
        dec.in1 = in_rs1;
        dec.in2 = imm_s;
        mw_raw  = 1'b1;
        legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_LUI: begin
        dec.in2 = imm_u;
        rw_raw  = 1'b1;
        legal   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.in1 = in_pc;
        dec.in2 = imm_u;
        rw_raw  = 1'b1;
        legal   = 1'b1;
      end
      OPC_JAL: begin
        dec.in1 = in_pc;
        dec.in2 = imm_j;
        rw_raw  = 1'b1;
        jmp_raw = 1'b1;
        legal   = 1'b1;
      end
      OPC_JALR: begin
        dec.in1 = in_rs1;
        dec.in2 = imm_i;
        rw_raw  = 1'b1;
        jmp_raw = 1'b1;
        legal   = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec.alu_ctrl = {1'b0, funct3};
        dec.in1      = in_rs1;
        dec.in2      = in_rs2;
        br_raw       = 1'b1;
        legal        = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      default: legal = 1'b0;
    endcase

    if (in_instr[1:0] != 2'b11)
      legal = 1'b0;

    dec.illegal   = !legal;
    dec.reg_write = legal && rw_raw && (rd != 5'd0);
    dec.mem_read  = legal && mr_raw;
    dec.mem_write = legal && mw_raw;
    dec.is_branch = legal && br_raw;
    dec.is_jump   = legal && jmp_raw;
  end

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // Pipeline register. Flush beats a simultaneous load; a stalled bundle
  // (out_valid & !out_ready) is never overwritten because in_ready is low.
  // The data fields only change on a load so they stay stable while held.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_alu_ctrl   = held.alu_ctrl;
  assign out_in1        = held.in1;
  assign out_in2        = held.in2;
  assign out_br_target  = held.br_target;
  assign out_link       = held.link;
  assign out_store_data = held.store_data;
  assign out_rd         = held.rd;
  assign out_funct3     = held.funct3;
  assign out_reg_write  = held.reg_write;
  assign out_mem_read   = held.mem_read;
  assign out_mem_write  = held.mem_write;
  assign out_is_branch  = held.is_branch;
  assign out_is_jump    = held.is_jump;
  assign out_illegal    = held.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed testbench for id_ex_stage. Each vector drives one instruction
// through the handshake and compares the registered bundle against values
// worked out by hand from the RV32I encodings.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [31:0] out_br_target;
  logic [31:0] out_link;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_is_branch;
  logic        out_is_jump;
  logic        out_illegal;

  int nVectors;
  int nMiscompares;

  id_ex_stage #(.STRICT_DECODE(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_ctrl   (out_alu_ctrl),
    .out_in1        (out_in1),
    .out_in2        (out_in2),
    .out_br_target  (out_br_target),
    .out_link       (out_link),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_funct3     (out_funct3),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_is_branch  (out_is_branch),
    .out_is_jump    (out_is_jump),
    .out_illegal    (out_illegal)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and sample #1 after it.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction with out_ready=1 so the previous bundle drains
  // and this one is loaded on the next edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2);
    in_instr  = instr;
    in_pc     = pc;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    stepCycle();
    in_valid  = 1'b0;
  endtask

  // Packs the five enables as {reg_write, mem_read, mem_write, is_branch, is_jump}.
  function automatic logic [31:0] enables();
    return {27'b0, out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump};
  endfunction

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    stepCycle();
    stepCycle();

    checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_in1",   out_in1, 32'd0);
    checkOutput("reset_ctrl",  {28'b0, out_alu_ctrl}, 32'd0);
    reset = 1'b0;
    stepCycle();

    // ADD x3,x1,x2
    applyStimulus(32'h002081B3, 32'h0000_0040, 32'd5, 32'd7);
    checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("add_ctrl",  {28'b0, out_alu_ctrl}, 32'h0);
    checkOutput("add_in1",   out_in1, 32'd5);
    checkOutput("add_in2",   out_in2, 32'd7);
    checkOutput("add_rd",    {27'b0, out_rd}, 32'd3);
    checkOutput("add_en",    enables(), 32'b10000);
    checkOutput("add_link",  out_link, 32'h0000_0044);

    // SUB x3,x1,x2
    applyStimulus(32'h402081B3, 32'h0, 32'd10, 32'd3);
    checkOutput("sub_ctrl", {28'b0, out_alu_ctrl}, 32'h8);
    checkOutput("sub_in1",  out_in1, 32'd10);

    // SRAI x5,x6,3
    applyStimulus(32'h40335293, 32'h0, 32'h8000_0000, 32'd0);
    checkOutput("srai_ctrl", {28'b0, out_alu_ctrl}, 32'hD);
    checkOutput("srai_in2",  out_in2, 32'd3);
    checkOutput("srai_rd",   {27'b0, out_rd}, 32'd5);
    checkOutput("srai_ill",  {31'b0, out_illegal}, 32'd0);

    // BEQ x1,x2,-8 at pc 0x100
    applyStimulus(32'hFE208CE3, 32'h0000_0100, 32'd1, 32'd2);
    checkOutput("beq_ctrl",   {28'b0, out_alu_ctrl}, 32'h0);
    checkOutput("beq_target", out_br_target, 32'h0000_00F8);
    checkOutput("beq_en",     enables(), 32'b00010);
    checkOutput("beq_in2",    out_in2, 32'd2);

    // LUI x7,0x12345 with a nonzero pc to show in1 is forced to 0
    applyStimulus(32'h123453B7, 32'h0000_0200, 32'hDEAD_BEEF, 32'd0);
    checkOutput("lui_in1", out_in1, 32'd0);
    checkOutput("lui_in2", out_in2, 32'h1234_5000);
    checkOutput("lui_rd",  {27'b0, out_rd}, 32'd7);

    // Undefined opcode 0x7F
    applyStimulus(32'h0000007F, 32'h0, 32'd1, 32'd1);
    checkOutput("bad_ill", {31'b0, out_illegal}, 32'd1);
    checkOutput("bad_en",  enables(), 32'd0);

    // LW x4,-4(x2): negative I-immediate sign extension
    applyStimulus(32'hFFC12203, 32'h0, 32'h0000_1000, 32'd0);
    checkOutput("lw_in2",    out_in2, 32'hFFFF_FFFC);
    checkOutput("lw_en",     enables(), 32'b11000);
    checkOutput("lw_funct3", {29'b0, out_funct3}, 32'd2);

    // JAL x1,0 at the top of memory: link wraps to 0
    applyStimulus(32'h000000EF, 32'hFFFF_FFFC, 32'd0, 32'd0);
    checkOutput("jal_link", out_link, 32'h0000_0000);
    checkOutput("jal_in1",  out_in1, 32'hFFFF_FFFC);
    checkOutput("jal_en",   enables(), 32'b10001);

    // ADD x0,x1,x2: write to x0 suppressed
    applyStimulus(32'h00208033, 32'h0, 32'd1, 32'd2);
    checkOutput("x0_en", enables(), 32'd0);

    // MUL encoding (funct7=0000001) rejected under strict decode
    applyStimulus(32'h022081B3, 32'h0, 32'd1, 32'd2);
    checkOutput("mul_ill", {31'b0, out_illegal}, 32'd1);
    checkOutput("mul_en",  enables(), 32'd0);

    // Backpressure: hold ADD (rs1=5) while SUB (rs1=9) waits upstream
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stepCycle();
    in_instr  = 32'h002081B3;
    in_rs1    = 32'd5;
    in_rs2    = 32'd7;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    stepCycle();
    in_instr  = 32'h402081B3;
    in_rs1    = 32'd9;
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("hold_in1",   out_in1, 32'd5);
      checkOutput("hold_ctrl",  {28'b0, out_alu_ctrl}, 32'h0);
      stepCycle();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("pulse_ready", {31'b0, in_ready}, 32'd1);
    stepCycle();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("pulse_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("pulse_in1",   out_in1, 32'd9);
    checkOutput("pulse_ctrl",  {28'b0, out_alu_ctrl}, 32'h8);

    // Flush with a simultaneous input transfer
    out_ready = 1'b1;
    in_valid  = 1'b1;
    flush     = 1'b1;
    stepCycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);

    // Reset while a bundle is held
    applyStimulus(32'h002081B3, 32'h0000_0040, 32'd5, 32'd7);
    out_ready = 1'b0;
    checkOutput("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in1",   out_in1, 32'd0);
    checkOutput("rst_link",  out_link, 32'd0);
    checkOutput("rst_rd",    {27'b0, out_rd}, 32'd0);
    checkOutput("rst_en",    enables(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
